// File: rtl/n64adv_ctrl_events_pkg.sv
// Shared definitions for the controller event block: button bit positions,
// navigation mask layout, default combos, stick threshold and combo FSM states.
package n64adv_ctrl_events_pkg;

  // Bit positions in the low half of the sniffed controller word
  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_Z     = 2;
  localparam int BTN_START = 3;
  localparam int BTN_DU    = 4;
  localparam int BTN_DD    = 5;
  localparam int BTN_DL    = 6;
  localparam int BTN_DR    = 7;
  localparam int BTN_JRST  = 8;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;
  localparam int BTN_CU    = 12;
  localparam int BTN_CD    = 13;
  localparam int BTN_CL    = 14;
  localparam int BTN_CR    = 15;

  // Navigation mask layout {R,L,B,A,Dr,Dl,Dd,Du}
  localparam int NAV_DU = 0;
  localparam int NAV_DD = 1;
  localparam int NAV_DL = 2;
  localparam int NAV_DR = 3;
  localparam int NAV_A  = 4;
  localparam int NAV_B  = 5;
  localparam int NAV_L  = 6;
  localparam int NAV_R  = 7;

  localparam logic [15:0] COMBO_RST_DEF  = 16'((1 << BTN_A) | (1 << BTN_B) | (1 << BTN_Z) |
                                               (1 << BTN_START) | (1 << BTN_R));
  localparam logic [15:0] COMBO_MENU_DEF = 16'((1 << BTN_DR) | (1 << BTN_L) | (1 << BTN_R) |
                                               (1 << BTN_CR));

  // Deflection must exceed this magnitude; the value itself does not count
  localparam logic signed [7:0] STICK_THRESH = 8'sd40;

  typedef enum logic [1:0] {
    CMB_IDLE,
    CMB_HOLD,
    CMB_FIRED
  } combo_state_e;

  function automatic logic [7:0] nav_mask(input logic [15:0] btn);
    logic [7:0] m;
    m         = '0;
    m[NAV_DU] = btn[BTN_DU];
    m[NAV_DD] = btn[BTN_DD];
    m[NAV_DL] = btn[BTN_DL];
    m[NAV_DR] = btn[BTN_DR];
    m[NAV_A]  = btn[BTN_A];
    m[NAV_B]  = btn[BTN_B];
    m[NAV_L]  = btn[BTN_L];
    m[NAV_R]  = btn[BTN_R];
    return m;
  endfunction

endpackage

// File: rtl/n64adv_combo_hold.sv
// Hold-to-fire detector: one pulse after COMBO is seen on HOLD_POLLS
// consecutive polls; re-arms only once the combo is released.
module n64adv_combo_hold
  import n64adv_ctrl_events_pkg::*;
#(
  parameter logic [15:0] COMBO      = COMBO_RST_DEF,
  parameter logic [7:0]  HOLD_POLLS = 8'd30
) (
  input  logic        CLK_4M,
  input  logic        nSRST_4M,
  input  logic        valid,
  input  logic [15:0] btn,
  input  logic        en,
  input  logic        abort,
  output logic        fire
);

  combo_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         fire_d;
  logic         match;

  assign match = (btn == COMBO);

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    if (!en || abort) begin
      state_d = CMB_IDLE;
      cnt_d   = '0;
    end else if (valid) begin
      unique case (state_q)
        CMB_IDLE, CMB_HOLD: begin
          if (match) begin
            cnt_d = (state_q == CMB_IDLE) ? 8'd1 : cnt_q + 8'd1;
            if (cnt_d == HOLD_POLLS) begin
              state_d = CMB_FIRED;
              fire_d  = 1'b1;
            end else begin
              state_d = CMB_HOLD;
            end
          end else begin
            state_d = CMB_IDLE;
            cnt_d   = '0;
          end
        end
        CMB_FIRED: begin
          if (!match) begin
            state_d = CMB_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = CMB_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      state_q <= CMB_IDLE;
      cnt_q   <= '0;
      fire    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire    <= fire_d;
    end
  end

endmodule

// File: rtl/n64adv_ctrl_events.sv
// Turns sniffed N64 controller words into combo pulses, auto-repeat menu
// navigation events and a controller-lost flag. Optional: N64ADV_STICK_NAV_EN.
module n64adv_ctrl_events
  import n64adv_ctrl_events_pkg::*;
#(
  parameter logic [7:0]  HOLD_POLLS  = 8'd30,
  parameter logic [5:0]  RPT_DELAY   = 6'd24,
  parameter logic [5:0]  RPT_RATE    = 6'd6,
  parameter logic [19:0] TIMEOUT_CYC = 20'd400000,
  parameter logic [15:0] COMBO_RST   = COMBO_RST_DEF,
  parameter logic [15:0] COMBO_MENU  = COMBO_MENU_DEF
) (
  input  logic        CLK_4M,
  input  logic        nSRST_4M,
  input  logic [31:0] ctrl_data_i,
  input  logic        ctrl_valid_i,
  input  logic        igr_en_i,
  output logic        igr_rst_o,
  output logic        igr_menu_o,
  output logic [7:0]  nav_evt_o,
  output logic        nav_evt_valid_o,
  output logic        ctrl_lost_o
);

  logic [19:0] wd_cnt_q;
  logic        timeout_hit;

  // A strobe in the same cycle as the expiry takes precedence
  assign timeout_hit = !ctrl_valid_i && (wd_cnt_q >= TIMEOUT_CYC - 20'd1);

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      wd_cnt_q    <= '0;
      ctrl_lost_o <= 1'b1;
    end else if (ctrl_valid_i) begin
      wd_cnt_q    <= '0;
      ctrl_lost_o <= 1'b0;
    end else begin
      if (wd_cnt_q != TIMEOUT_CYC) wd_cnt_q <= wd_cnt_q + 20'd1;
      if (timeout_hit) ctrl_lost_o <= 1'b1;
    end
  end

  n64adv_combo_hold #(.COMBO(COMBO_RST), .HOLD_POLLS(HOLD_POLLS)) u_combo_rst (
    .CLK_4M   (CLK_4M),
    .nSRST_4M (nSRST_4M),
    .valid    (ctrl_valid_i),
    .btn      (ctrl_data_i[15:0]),
    .en       (igr_en_i),
    .abort    (timeout_hit),
    .fire     (igr_rst_o)
  );

  n64adv_combo_hold #(.COMBO(COMBO_MENU), .HOLD_POLLS(HOLD_POLLS)) u_combo_menu (
    .CLK_4M   (CLK_4M),
    .nSRST_4M (nSRST_4M),
    .valid    (ctrl_valid_i),
    .btn      (ctrl_data_i[15:0]),
    .en       (igr_en_i),
    .abort    (timeout_hit),
    .fire     (igr_menu_o)
  );

  logic [7:0] nav_m;

`ifdef N64ADV_STICK_NAV_EN
  logic signed [7:0] stick_x, stick_y;
  assign stick_x = $signed(ctrl_data_i[23:16]);
  assign stick_y = $signed(ctrl_data_i[31:24]);

  always_comb begin
    nav_m = nav_mask(ctrl_data_i[15:0]);
    if (stick_x >  STICK_THRESH) nav_m[NAV_DR] = 1'b1;
    if (stick_x < -STICK_THRESH) nav_m[NAV_DL] = 1'b1;
    if (stick_y >  STICK_THRESH) nav_m[NAV_DU] = 1'b1;
    if (stick_y < -STICK_THRESH) nav_m[NAV_DD] = 1'b1;
  end
`else
  logic unused_stick;
  assign unused_stick = ^ctrl_data_i[31:16];
  assign nav_m        = nav_mask(ctrl_data_i[15:0]);
`endif

  logic [7:0] prev_q, prev_d, evt_d;
  logic [5:0] rpt_q, rpt_d, rpt_inc;
  logic       evt_vld_d;

  // Saturating increment; the reload keeps it at or below RPT_DELAY anyway
  assign rpt_inc = (rpt_q == 6'h3F) ? rpt_q : rpt_q + 6'd1;

  always_comb begin
    prev_d    = prev_q;
    rpt_d     = rpt_q;
    evt_d     = '0;
    evt_vld_d = 1'b0;
    if (timeout_hit) begin
      prev_d = '0;
      rpt_d  = '0;
    end else if (ctrl_valid_i) begin
      prev_d = nav_m;
      if (nav_m != prev_q) begin
        rpt_d     = '0;
        evt_d     = nav_m & ~prev_q;
        evt_vld_d = |evt_d;
      end else if (nav_m != '0) begin
        if (rpt_inc == RPT_DELAY) begin
          evt_d     = nav_m;
          evt_vld_d = 1'b1;
          rpt_d     = RPT_DELAY - RPT_RATE;
        end else begin
          rpt_d = rpt_inc;
        end
      end else begin
        rpt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      prev_q          <= '0;
      rpt_q           <= '0;
      nav_evt_o       <= '0;
      nav_evt_valid_o <= 1'b0;
    end else begin
      prev_q          <= prev_d;
      rpt_q           <= rpt_d;
      nav_evt_o       <= evt_d;
      nav_evt_valid_o <= evt_vld_d;
    end
  end

endmodule

// File: tb/tb_n64adv_ctrl_events.sv
// Scoreboard bench for n64adv_ctrl_events: each poll pushes its expected
// response; a monitor compares it one cycle after the strobe.
module tb_n64adv_ctrl_events;

  localparam int TO = 300;

`ifdef N64ADV_STICK_NAV_EN
  localparam logic [7:0] STICK_DR = 8'h08;
  localparam logic [7:0] STICK_DD = 8'h02;
`else
  localparam logic [7:0] STICK_DR = 8'h00;
  localparam logic [7:0] STICK_DD = 8'h00;
`endif

  typedef struct {
    int         idx;
    logic       rst;
    logic       menu;
    logic [7:0] nav;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic        igr_en;
  logic        igr_rst;
  logic        igr_menu;
  logic [7:0]  nav_evt;
  logic        nav_evt_valid;
  logic        ctrl_lost;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   poll_idx = 0;
  logic run   = 1'b0;
  logic vseen = 1'b0;

  n64adv_ctrl_events #(.TIMEOUT_CYC(20'(TO))) dut (
    .CLK_4M          (clk),
    .nSRST_4M        (rst_n),
    .ctrl_data_i     (ctrl_data),
    .ctrl_valid_i    (ctrl_valid),
    .igr_en_i        (igr_en),
    .igr_rst_o       (igr_rst),
    .igr_menu_o      (igr_menu),
    .nav_evt_o       (nav_evt),
    .nav_evt_valid_o (nav_evt_valid),
    .ctrl_lost_o     (ctrl_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Response to a strobe appears on the edge that samples it
  always @(posedge clk) vseen <= ctrl_valid;

  always @(negedge clk) begin
    if (run) begin
      if (vseen) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("poll%0d", e.idx),
                {21'd0, igr_rst, igr_menu, nav_evt_valid, nav_evt},
                {21'd0, e.rst, e.menu, |e.nav, e.nav});
        end
      end else begin
        check("quiet", {29'd0, igr_rst, igr_menu, nav_evt_valid}, 32'd0);
      end
    end
  end

  task automatic poll(input logic [15:0] btn, input logic [15:0] stick,
                      input logic e_rst, input logic e_menu, input logic [7:0] e_nav);
    exp_t e;
    poll_idx++;
    e.idx  = poll_idx;
    e.rst  = e_rst;
    e.menu = e_menu;
    e.nav  = e_nav;
    sb.push_back(e);
    @(negedge clk);
    ctrl_data  = {stick, btn};
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steady hold from a released state: first press, repeat at 25, then every 6
  function automatic logic [7:0] rpt_exp(input int p, input logic [7:0] mask);
    if (p == 1 || (p >= 25 && (p - 25) % 6 == 0)) return mask;
    return 8'h00;
  endfunction

  task automatic hold(input logic [15:0] btn, input int n, input int fire_at,
                      input logic is_menu, input logic [7:0] mask);
    for (int p = 1; p <= n; p++)
      poll(btn, 16'h0000, (p == fire_at) && !is_menu, (p == fire_at) && is_menu, rpt_exp(p, mask));
  endtask

  task automatic release_all();
    poll(16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n      = 1'b0;
    ctrl_data  = '0;
    ctrl_valid = 1'b0;
    igr_en     = 1'b1;
    idle(4);
    check("rst_lost", {31'd0, ctrl_lost}, 32'd1);
    check("rst_outs", {21'd0, igr_rst, igr_menu, nav_evt_valid, nav_evt}, 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    idle(2);

    // Reset combo: one pulse at poll 30, silent through 40, re-fires after release
    hold(16'h080F, 40, 30, 1'b0, 8'hB0);
    check("lost_cleared", {31'd0, ctrl_lost}, 32'd0);
    release_all();
    hold(16'h080F, 30, 30, 1'b0, 8'hB0);
    release_all();

    // Broken hold and disabled detection never fire
    hold(16'h080F, 29, 0, 1'b0, 8'hB0);
    release_all();
    hold(16'h080F, 29, 0, 1'b0, 8'hB0);
    release_all();
    igr_en = 1'b0;
    hold(16'h080F, 30, 0, 1'b0, 8'hB0);
    igr_en = 1'b1;
    release_all();

    // Menu combo
    hold(16'h8C80, 30, 30, 1'b1, 8'hC8);
    release_all();

    // Du held 60 polls, then Dr added restarts the repeat timer
    hold(16'h0010, 60, 0, 1'b0, 8'h01);
    for (int p = 1; p <= 30; p++)
      poll(16'h0090, 16'h0000, 1'b0, 1'b0, (p == 1) ? 8'h08 : rpt_exp(p, 8'h09));
    release_all();

    // Stick deflection {Y,X}
    poll(16'h0000, 16'h0029, 1'b0, 1'b0, STICK_DR);
    release_all();
    poll(16'h0000, 16'h0028, 1'b0, 1'b0, 8'h00);
    release_all();
    poll(16'h0000, 16'hC400, 1'b0, 1'b0, STICK_DD);
    release_all();

    // Reset mid-hold aborts; the full hold is needed again
    hold(16'h080F, 20, 0, 1'b0, 8'hB0);
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    check("midrst_lost", {31'd0, ctrl_lost}, 32'd1);
    rst_n = 1'b1;
    idle(1);
    hold(16'h080F, 30, 30, 1'b0, 8'hB0);
    release_all();

    // Timeout aborts a hold and clears the previous mask
    hold(16'h080F, 10, 0, 1'b0, 8'hB0);
    idle(TO);
    check("lost_set", {31'd0, ctrl_lost}, 32'd1);
    hold(16'h080F, 30, 30, 1'b0, 8'hB0);
    release_all();

    // Lost clears one cycle after the next strobe
    idle(TO);
    check("lost_set2", {31'd0, ctrl_lost}, 32'd1);
    release_all();
    check("lost_clear", {31'd0, ctrl_lost}, 32'd0);

    // Strobe on the expiry cycle wins
    idle(TO - 2);
    release_all();
    check("lost_race", {31'd0, ctrl_lost}, 32'd0);

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n64adv_ctrl_events.md
Name: n64adv_ctrl_events

Overview:
- Consumes the 32-bit controller words produced by the controller sniffer, one per N64 poll, in the same 4 MHz domain.
- Converts raw button state into qualified events:
  - hold-to-fire combo pulses for the in-game reset and the OSD-menu toggle;
  - press/auto-repeat navigation events for the OSD menu;
  - a controller-lost flag.
- Removes combo timing and repeat timing from the NIOS software loop.

Parameters:
- HOLD_POLLS, 8'd30: consecutive polls a combo must be held before it fires (~0.5 s at 60 Hz polling).
- RPT_DELAY, 6'd24: polls a navigation mask must be held before the first repeat.
- RPT_RATE, 6'd6: polls between subsequent repeats; RPT_RATE <= RPT_DELAY is required.
- TIMEOUT_CYC, 20'd400000: CLK_4M cycles without a valid word before the controller is declared lost (~100 ms).
- COMBO_RST, 16'h080F: button word for the reset combo (A+B+Z+Start+R).
- COMBO_MENU, 16'h8C80: button word for the menu combo (Dr+L+R+Cr).

Ports:
- CLK_4M  in  1  block clock (4 MHz).
- nSRST_4M  in  1  reset, asynchronous assert, active-low.
- ctrl_data_i  in  32  controller word.
  - bit 0 A, 1 B, 2 Z, 3 Start, 4 Du, 5 Dd, 6 Dl, 7 Dr.
  - bit 8 joystick-reset, 9 zero, 10 L, 11 R, 12 Cu, 13 Cd, 14 Cl, 15 Cr.
  - bits [23:16] stick X, [31:24] stick Y, both signed.
- ctrl_valid_i  in  1  one-cycle strobe; ctrl_data_i is stable in that cycle.
- igr_en_i  in  1  enables combo detection.
- igr_rst_o  out  1  one-cycle pulse when the reset combo fires.
- igr_menu_o  out  1  one-cycle pulse when the menu combo fires.
- nav_evt_o  out  8  navigation event mask {R,L,B,A,Dr,Dl,Dd,Du}.
- nav_evt_valid_o  out  1  one-cycle strobe qualifying nav_evt_o.
- ctrl_lost_o  out  1  high while no controller word has arrived within TIMEOUT_CYC.

Behaviour:
- Reset values:
  - all outputs 0 except ctrl_lost_o = 1;
  - all counters 0;
  - previous navigation mask = 0.
- All outputs are registered. Latency from ctrl_valid_i to any pulse/strobe is exactly 1 cycle. Pulses never last more than 1 cycle.
- Combo FSM: one instance per combo, states IDLE, HOLD, FIRED. Transitions are evaluated only on ctrl_valid_i, using match = (ctrl_data_i[15:0] == COMBO):
  - IDLE, match -> HOLD, cnt = 1.
  - HOLD, match -> cnt+1. When cnt+1 == HOLD_POLLS: go to FIRED and pulse the output.
  - HOLD, no match -> IDLE, cnt = 0.
  - FIRED, no match -> IDLE. FIRED, match -> stay, no further pulse (one pulse per hold).
  - igr_en_i = 0 forces IDLE with cnt = 0, in every cycle.
- Navigation mask m = {b11, b10, b1, b0, b7, b6, b5, b4} of ctrl_data_i. Evaluated on ctrl_valid_i:
  - m != prev: rpt_cnt = 0. The event is m & ~prev (newly pressed bits only); the strobe fires if that result is nonzero.
  - m == prev, m != 0: rpt_cnt+1. When it reaches RPT_DELAY, emit event m and reload rpt_cnt = RPT_DELAY - RPT_RATE.
  - m == 0: rpt_cnt = 0.
  - prev <= m.
- rpt_cnt is 6 bits and never wraps.
- Watchdog: 20-bit counter, cleared on ctrl_valid_i, otherwise incremented.
  - On reaching TIMEOUT_CYC: saturate, set ctrl_lost_o = 1, force both FSMs to IDLE, clear prev and rpt_cnt.
  - ctrl_lost_o clears 1 cycle after the next ctrl_valid_i.
  - If ctrl_valid_i and the timeout hit occur in the same cycle, ctrl_valid_i wins.
- Both combos may fire in the same cycle; a combo may coincide with a nav event. All outputs are independent.
- Reset asserted mid-hold or mid-repeat aborts with no pulse. After release, the combo must be held the full HOLD_POLLS again.

Optional Feature:
- Macro N64ADV_STICK_NAV_EN.
- Defined: stick deflection is ORed into the Du/Dd/Dl/Dr bits of m before evaluation:
  - X > +40 -> Dr; X < -40 -> Dl;
  - Y > +40 -> Du; Y < -40 -> Dd;
  - signed 8-bit compare, the threshold value itself does not trigger.
  - Repeat behaviour is identical to the D-pad.
- Not defined: bits [31:16] are ignored and no stick logic is synthesised.

Decomposition:
- Shared header in vh/ holds:
  - button bit-index localparams (A..Cr);
  - nav mask bit order;
  - default combo constants;
  - stick threshold.
- Sub-module n64adv_combo_hold: combo FSM plus counter, parameterised by COMBO and HOLD_POLLS, instantiated twice.

Test Plan:
- Reset combo: send 16'h080F for 30 polls with igr_en_i = 1 -> single igr_rst_o pulse 1 cycle after the 30th strobe; none on polls 31..40; release then 30 more polls -> second pulse.
- Broken hold: 16'h080F for 29 polls, 1 poll of 16'h0000, then 29 polls -> no pulse. igr_en_i = 0 with 30 polls -> no pulse.
- Navigation: Du held 60 polls -> events on poll 1, poll 25, then every 6 polls (31, 37, 43, 49, 55); mask = 8'h01 each time.
- Navigation change: Du held, add Dr -> event 8'h09 & ~8'h01 = 8'h08 and rpt_cnt restarts.
- Timeout: no strobe for 400000 cycles -> ctrl_lost_o = 1 and HOLD aborted. Next strobe -> ctrl_lost_o = 0 one cycle later. Strobe landing on the timeout cycle -> ctrl_lost_o stays 0.
- Stick (with macro): X = 8'sd41 -> Dr event; X = 8'sd40 -> none; Y = -8'sd60 -> Dd event. Without the macro: no events.
